hs_tx_sequencer: RTL
====================

Name: hs_tx_sequencer

Overview:
- HS-mode transmit sequencer for the lane: the transmit-side counterpart of the HS receive trailer detector.
- On request, serializes the SOT sync byte, then a byte stream LSB-first, then an HS trailer.
- The trailer is the inverse of the last payload bit, held constant for TRAIL_BITS bit-times. It is long enough for the far-end comparator to declare trailer_done.
- Sits between the lane byte interface and the HS line driver, one bit per clock.

Parameters:
- DATA_WIDTH, 8, payload word width; bits per serialized word.
- SYNC_BYTE, 8'hB8, SOT leader pattern sent LSB-first before payload.
- TRAIL_BITS, 187, trailer length in bit-times. Must be at least the receiver's equal-sample threshold plus 1; legal range 1..255.

Ports:
- clk_serializer  in  1  bit-rate clock; one HS bit per rising edge.
- RST  in  1  synchronous, active-high reset.
- tx_enable  in  1  session enable; deassertion aborts.
- tx_data  in  DATA_WIDTH  payload word.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  marks final word of burst.
- tx_ready  out  1  sequencer accepts word this cycle.
- HS_TX_DATA  out  1  serial line bit to driver.
- hs_tx_active  out  1  high during SYNC, DATA, TRAIL.
- trailer_done  out  1  one-cycle pulse after last trailer bit.

Behaviour:
- Single clock; RST is synchronous and active-high, sampled on the clk_serializer rising edge. RST has priority over everything.
- Reset values: state=IDLE, HS_TX_DATA=0, tx_ready=0, hs_tx_active=0, trailer_done=0, all counters and shifters 0, last_bit=0, underrun=0.
- FSM states: IDLE, SYNC, DATA, TRAIL, DONE.
- IDLE:
  - HS_TX_DATA=0, tx_ready=0.
  - If tx_enable && tx_valid at cycle N: go to SYNC. The sync shifter is loaded with SYNC_BYTE. Word is not consumed.
  - Sync bit0 appears on HS_TX_DATA at cycle N+1.
- SYNC:
  - Shift out SYNC_BYTE over DATA_WIDTH cycles, LSB first.
  - tx_ready=1 on the last sync bit cycle.
- DATA:
  - Each word occupies DATA_WIDTH consecutive cycles, LSB first; no gaps between words.
  - tx_ready=1 only on the last bit cycle of the current word.
- Handshake:
  - Transfer occurs when tx_ready && tx_valid. tx_data and tx_last are captured into the shifter; the first bit goes out the next cycle.
  - The first payload bit follows the last sync bit with no gap (cycle N+9 for DATA_WIDTH=8).
  - tx_ready is never asserted outside the last-bit cycle.
- End of burst:
  - After the last bit of a word captured with tx_last=1, go to TRAIL.
  - last_bit holds the final transmitted payload bit.
- Underrun:
  - tx_ready=1 with tx_valid=0 (in SYNC or DATA) is treated as an implicit tx_last.
  - Go to TRAIL. If in SYNC, last_bit is SYNC_BYTE[DATA_WIDTH-1].
- TRAIL:
  - HS_TX_DATA = ~last_bit for exactly TRAIL_BITS cycles.
  - Counter width is 8 bits, counts 0..TRAIL_BITS-1 with no wrap. The terminal count moves to DONE.
- DONE:
  - trailer_done=1 for one cycle, HS_TX_DATA=0, hs_tx_active=0.
  - Next state is IDLE. A new burst may be requested in the following cycle.
- Abort:
  - tx_enable=0 in any state other than IDLE forces IDLE on the next edge.
  - HS_TX_DATA=0, no trailer, no trailer_done, tx_ready=0.
  - In the abort cycle, tx_ready is gated low so no word is consumed.
- Simultaneous events: RST beats abort; abort beats handshake and terminal count.

Optional Feature:
- Macro: HS_TX_UNDERRUN_FLAG_EN.
- With the macro: extra port "underrun out 1".
  - Set on an underrun event.
  - Sticky until the next IDLE->SYNC transition or RST.
- Without the macro: port absent; underrun behaviour (implicit last, trailer) is unchanged.

Test Plan:
- Single word:
  - Stimulus: RST 2 cycles; tx_enable=1; tx_valid=1, tx_data=8'h5A, tx_last=1 at cycle 0.
  - Sync bits: cycles 1-8 show 0,0,0,1,1,1,0,1 (0xB8 LSB-first).
  - Handshake: tx_ready=1 at cycle 8 with a transfer.
  - Payload bits: cycles 9-16 show 0,1,0,1,1,0,1,0.
  - Trailer: HS_TX_DATA=1 on cycles 17-203.
  - End: trailer_done pulse at cycle 204; IDLE at 205.
- Back-to-back words:
  - Stimulus: tx_data 8'hFF, 8'h00 (tx_last on the second), tx_valid held high.
  - Payload: 8 ones then 8 zeros, no gap; tx_ready pulses exactly at the two last-bit cycles.
  - Trailer: all ones for 187 cycles.
- Underrun:
  - Stimulus: one word 8'h80 with tx_last=0, then tx_valid=0.
  - Trailer: 0 for 187 cycles after bit7=1; trailer_done pulses.
  - With HS_TX_UNDERRUN_FLAG_EN: underrun=1 until the next start.
- Abort:
  - Stimulus: tx_enable=0 at the 50th trailer cycle.
  - Next cycle: IDLE, HS_TX_DATA=0, hs_tx_active=0; trailer_done never asserted.
- Reset mid-DATA:
  - Stimulus: RST=1 for 1 cycle during payload bit 3.
  - Next edge: all outputs return to reset values; a new request then produces a fresh SYNC_BYTE.
- Loopback:
  - Stimulus: drive HS_TX_DATA into the HS receive trailer detector, sampling every bit-time.
  - Required: the receiver's trailer_done asserts before this block's trailer_done pulse.

Source files
------------

// File: rtl/hs_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// hs_tx_sequencer_if
//
// Purpose:
//   Lane byte-side handshake bundle between the word source (master) and the
//   HS transmit sequencer (slave).
//
// Signals:
//   tx_data   DATA_WIDTH  payload word, qualified by tx_valid
//   tx_valid  1           tx_data / tx_last are valid this cycle
//   tx_last   1           current word is the final word of the burst
//   tx_ready  1           sequencer consumes the presented word this cycle
//
// Modports:
//   master  drives tx_data/tx_valid/tx_last, observes tx_ready
//   slave   observes tx_data/tx_valid/tx_last, drives tx_ready
// ---------------------------------------------------------------------------
interface hs_tx_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/hs_tx_sequencer.sv
// ---------------------------------------------------------------------------
// hs_tx_sequencer
//
// Purpose:
//   HS-mode transmit sequencer for one lane. On request it serializes the
//   SOT sync byte, then the payload words LSB-first with no gaps, then an HS
//   trailer: the inverse of the last transmitted payload bit held for
//   TRAIL_BITS bit-times, long enough for the far-end equal-sample detector
//   to declare its own trailer_done. One HS bit leaves per clock.
//
// Parameters:
//   DATA_WIDTH  bits per serialized word (>= 2)
//   SYNC_BYTE   SOT leader pattern, sent LSB-first before the payload
//   TRAIL_BITS  trailer length in bit-times, 1..255
//
// Ports:
//   clk_serializer  in   bit-rate clock, one HS bit per rising edge
//   RST             in   synchronous active-high reset, highest priority
//   tx_enable       in   session enable; dropping it aborts the burst
//   tx_bus          slave modport: tx_data, tx_valid, tx_last, tx_ready
//   HS_TX_DATA      out  serial bit to the HS line driver
//   hs_tx_active    out  high during SYNC, DATA and TRAIL
//   trailer_done    out  one-cycle pulse after the last trailer bit
//   underrun        out  (only with HS_TX_UNDERRUN_FLAG_EN) sticky flag set
//                        when the source had no word at a ready slot;
//                        cleared on the next burst start or RST
//
// Build option:
//   HS_TX_UNDERRUN_FLAG_EN  adds the underrun output. Underrun handling
//                           itself (implicit last word, normal trailer) is
//                           identical with or without it.
//
// Timing (DATA_WIDTH = 8, request seen in cycle N):
//   N+1..N+8   sync bits, tx_ready high in N+8
//   N+9..      payload, tx_ready high on each word's last bit unless that
//              word carried tx_last
//   then       TRAIL_BITS cycles of ~last_bit, then one DONE cycle
// ---------------------------------------------------------------------------
module hs_tx_sequencer #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hB8,
    parameter int unsigned           TRAIL_BITS = 187
) (
    input  logic              clk_serializer,
    input  logic              RST,
    input  logic              tx_enable,
    hs_tx_sequencer_if.slave  tx_bus,
    output logic              HS_TX_DATA,
    output logic              hs_tx_active,
    output logic              trailer_done
`ifdef HS_TX_UNDERRUN_FLAG_EN
    ,
    output logic              underrun
`endif
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Index of the last bit of a word, and of the bit before it: tx_ready is
    // registered, so it is armed while the second-to-last bit is on the line.
    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(DATA_WIDTH - 2);
    localparam logic [7:0]       TRAIL_LAST   = 8'(TRAIL_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;      // bits still to be sent of the current word
    logic [DATA_WIDTH-1:0] shift_down;     // shift_reg moved one place towards bit 0
    logic [CNT_W-1:0]      bit_cnt_reg;    // index of the bit currently on the line
    logic [7:0]            trail_cnt_reg;  // trailer bit-times already on the line, minus 1
    logic                  hs_data_reg;
    logic                  ready_reg;
    logic                  active_reg;
    logic                  done_reg;
    logic                  last_flag_reg;  // current word was captured with tx_last
    logic                  last_bit_reg;   // final bit put on the line before the trailer

    // ------------------------------------------------------------------
    // Right-shift network for the serializer.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
            assign shift_down[gi] = shift_reg[gi + 1];
        end
    endgenerate
    assign shift_down[DATA_WIDTH-1] = 1'b0;

    // ------------------------------------------------------------------
    // Sequencer FSM. All outputs are registered except tx_ready, which is
    // gated by tx_enable so that no word is consumed in an abort cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_serializer) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            trail_cnt_reg <= '0;
            hs_data_reg   <= 1'b0;
            ready_reg     <= 1'b0;
            active_reg    <= 1'b0;
            done_reg      <= 1'b0;
            last_flag_reg <= 1'b0;
            last_bit_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    hs_data_reg <= 1'b0;
                    ready_reg   <= 1'b0;
                    active_reg  <= 1'b0;
                    // The request word is not consumed here; it is taken at
                    // the last sync bit through the normal handshake.
                    if (tx_enable && tx_bus.tx_valid) begin
                        state_reg     <= ST_SYNC;
                        shift_reg     <= SYNC_BYTE >> 1;
                        hs_data_reg   <= SYNC_BYTE[0];
                        bit_cnt_reg   <= '0;
                        last_flag_reg <= 1'b0;
                        active_reg    <= 1'b1;
                    end
                end

                ST_SYNC, ST_DATA: begin
                    if (!tx_enable) begin
                        // Abort: drop straight to IDLE, no trailer.
                        state_reg     <= ST_IDLE;
                        shift_reg     <= '0;
                        bit_cnt_reg   <= '0;
                        hs_data_reg   <= 1'b0;
                        ready_reg     <= 1'b0;
                        active_reg    <= 1'b0;
                        last_flag_reg <= 1'b0;
                    end else if (bit_cnt_reg != LAST_IDX) begin
                        shift_reg   <= shift_down;
                        hs_data_reg <= shift_reg[0];
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        // No ready slot after a word that carried tx_last.
                        ready_reg   <= (bit_cnt_reg == PRE_LAST_IDX) && !last_flag_reg;
                    end else if (ready_reg && tx_bus.tx_valid) begin
                        // Handshake on the last bit: next word follows gap-free.
                        state_reg     <= ST_DATA;
                        shift_reg     <= tx_bus.tx_data >> 1;
                        hs_data_reg   <= tx_bus.tx_data[0];
                        bit_cnt_reg   <= '0;
                        last_flag_reg <= tx_bus.tx_last;
                        ready_reg     <= 1'b0;
                    end else begin
                        // Either the word just finished carried tx_last
                        // (ready_reg low) or the source underran (ready_reg
                        // high, no valid). Both end the burst the same way;
                        // the bit on the line now is the final one.
                        state_reg     <= ST_TRAIL;
                        shift_reg     <= '0;
                        bit_cnt_reg   <= '0;
                        trail_cnt_reg <= '0;
                        last_bit_reg  <= hs_data_reg;
                        hs_data_reg   <= ~hs_data_reg;
                        ready_reg     <= 1'b0;
                        last_flag_reg <= 1'b0;
                    end
                end

                ST_TRAIL: begin
                    if (!tx_enable) begin
                        state_reg     <= ST_IDLE;
                        trail_cnt_reg <= '0;
                        hs_data_reg   <= 1'b0;
                        active_reg    <= 1'b0;
                    end else if (trail_cnt_reg == TRAIL_LAST) begin
                        state_reg     <= ST_DONE;
                        trail_cnt_reg <= '0;
                        hs_data_reg   <= 1'b0;
                        active_reg    <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        trail_cnt_reg <= trail_cnt_reg + 8'd1;
                        hs_data_reg   <= ~last_bit_reg;
                    end
                end

                ST_DONE: begin
                    state_reg   <= ST_IDLE;
                    hs_data_reg <= 1'b0;
                    active_reg  <= 1'b0;
                    ready_reg   <= 1'b0;
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    hs_data_reg <= 1'b0;
                    ready_reg   <= 1'b0;
                    active_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_bus.tx_ready = ready_reg && tx_enable;
    assign HS_TX_DATA      = hs_data_reg;
    assign hs_tx_active    = active_reg;
    assign trailer_done    = done_reg;

`ifdef HS_TX_UNDERRUN_FLAG_EN
    // ------------------------------------------------------------------
    // Sticky underrun indication: a ready slot passed with no word offered.
    // Survives abort and DONE; only a new burst start or RST clears it.
    // ------------------------------------------------------------------
    logic start_evt;
    logic underrun_evt;
    logic underrun_reg;

    assign start_evt    = (state_reg == ST_IDLE) && tx_enable && tx_bus.tx_valid;
    assign underrun_evt = ((state_reg == ST_SYNC) || (state_reg == ST_DATA)) &&
                          tx_enable && ready_reg && !tx_bus.tx_valid;

    always_ff @(posedge clk_serializer) begin
        if (RST) begin
            underrun_reg <= 1'b0;
        end else if (start_evt) begin
            underrun_reg <= 1'b0;
        end else if (underrun_evt) begin
            underrun_reg <= 1'b1;
        end
    end

    assign underrun = underrun_reg;
`endif

endmodule
